uart_tx_arb: RTL and testbench

- Round-robin arbiter that shares the single MCU UART transmitter (the TXD path) among NREQ byte-stream requesters, e.g. core printf buffer, debug agent and DMA.
- The grant is locked per packet, so packets from different requesters never interleave on TXD.
- Sits between the requesters and the UART TX holding register, with one registered output stage.

---
 rtl/uart_tx_arb_pkg.sv | 37 +++
 rtl/uart_tx_arb_if.sv | 35 +++
 rtl/uart_arb_rr_pick.sv | 23 ++
 rtl/uart_tx_arb.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter: FSM state encoding,
// grant index width and the round-robin pick function.
package uart_arb_pkg;

  localparam int unsigned GNT_W   = 3;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_e;

  typedef struct packed {
    logic             any;
    logic [GNT_W-1:0] idx;
  } pick_t;

  // Lowest set index at or above ptr; if none, lowest set index overall.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [GNT_W-1:0]   ptr);
    logic [MAX_REQ-1:0] masked;
    pick_t              res;
    res    = '0;
    masked = valid & ({MAX_REQ{1'b1}} << ptr);
    if (masked == '0) begin
      masked = valid;
    end
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (masked[i]) begin
        res.any = 1'b1;
        res.idx = GNT_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between the byte-stream requesters, the arbiter and the
// UART TX holding register. master = requester/UART side, slave = arbiter.
interface uart_tx_arb_if #(
  parameter int unsigned NREQ = 4
);

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output tx_ready,
    input  req_ready,
    input  tx_valid,
    input  tx_data
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  tx_ready,
    output req_ready,
    output tx_valid,
    output tx_data
  );

endinterface

// File: rtl/uart_arb_rr_pick.sv
// Combinational round-robin selector: first valid requester at or after ptr,
// wrapping to the lowest valid index.
module uart_arb_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]  valid_i,
  input  logic [GNT_W-1:0] ptr_i,
  output logic [GNT_W-1:0] idx_o,
  output logic             any_o
);

  pick_t pick;

  // Zero-extend to the package width and pick.
  always_comb begin
    pick  = rr_pick(MAX_REQ'(valid_i), ptr_i);
    idx_o = pick.idx;
    any_o = pick.any;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locked round-robin arbiter sharing one UART TX holding register
// among NREQ byte-stream requesters, with one registered output stage and an
// idle timeout that revokes a stalled grant.
// Optional: define UART_TX_ARB_PRIO0_EN to give requester 0 fixed top
// priority in IDLE (others stay round-robin, ptr never points at 0).
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TMO_CYC = 200
) (
  input  logic             CLK,
  input  logic             RSTN,
  uart_tx_arb_if.slave     bus,
  output logic [GNT_W-1:0] gnt_id,
  output logic             busy,
  output logic             tmo_evt
);

  arb_state_e       state_q;
  logic [GNT_W-1:0] gnt_q;
  logic [GNT_W-1:0] ptr_q;
  logic [TMO_W-1:0] cnt_q;
  logic             tx_valid_q;
  logic [7:0]       tx_data_q;
  logic             tmo_q;

  logic [NREQ-1:0]  gnt_oh;
  logic             gnt_valid;
  logic             gnt_last;
  logic [7:0]       gnt_data;
  logic             slot_free;
  logic             accept;

  logic [NREQ-1:0]  pick_valid;
  logic [GNT_W-1:0] rr_idx;
  logic             rr_any;
  logic [GNT_W-1:0] pick_idx;
  logic             pick_any;
  logic [GNT_W-1:0] ptr_next;

  // Decode the granted requester and mux its handshake signals.
  always_comb begin
    gnt_oh    = '0;
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q == GNT_W'(i)) begin
        gnt_oh[i] = 1'b1;
        gnt_valid = bus.req_valid[i];
        gnt_last  = bus.req_last[i];
        gnt_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  // The output register can take a byte when empty or draining this cycle.
  assign slot_free     = !tx_valid_q || bus.tx_ready;
  assign accept        = (state_q == ARB_LOCK) && gnt_valid && slot_free;
  assign bus.req_ready = ((state_q == ARB_LOCK) && slot_free) ? gnt_oh : '0;

`ifdef UART_TX_ARB_PRIO0_EN
  localparam logic [NREQ-1:0] Bit0 = NREQ'(1);
  assign pick_valid = bus.req_valid & ~Bit0;
  assign pick_idx   = bus.req_valid[0] ? '0 : rr_idx;
  assign pick_any   = bus.req_valid[0] | rr_any;
  assign ptr_next   = (gnt_q == GNT_W'(NREQ - 1)) ? GNT_W'(1) : gnt_q + GNT_W'(1);
`else
  assign pick_valid = bus.req_valid;
  assign pick_idx   = rr_idx;
  assign pick_any   = rr_any;
  assign ptr_next   = (gnt_q == GNT_W'(NREQ - 1)) ? '0 : gnt_q + GNT_W'(1);
`endif

  uart_arb_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .valid_i (pick_valid),
    .ptr_i   (ptr_q),
    .idx_o   (rr_idx),
    .any_o   (rr_any)
  );

  // Arbitration FSM, timeout counter and output register.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tmo_q      <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      // Reload and drain in the same cycle keeps 1 byte/cycle throughput.
      if (accept) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= gnt_data;
      end else if (bus.tx_ready) begin
        tx_valid_q <= 1'b0;
      end
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            gnt_q   <= pick_idx;
            cnt_q   <= '0;
            state_q <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          if (accept) begin
            cnt_q <= '0;
            if (gnt_last) begin
              ptr_q   <= ptr_next;
              state_q <= ARB_IDLE;
            end
          end else if (!gnt_valid) begin
            // Only a silent requester ages; backpressure holds the count.
            if (cnt_q == TMO_W'(TMO_CYC - 1)) begin
              tmo_q   <= 1'b1;
              cnt_q   <= '0;
              ptr_q   <= ptr_next;
              state_q <= ARB_IDLE;
            end else begin
              cnt_q <= cnt_q + TMO_W'(1);
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign gnt_id      = gnt_q;
  assign busy        = (state_q == ARB_LOCK);
  assign tmo_evt     = tmo_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: directed packets push their expected
// byte order into a queue; a negedge monitor pops on every TX handshake.
module tb_uart_tx_arb;

  logic       CLK  = 1'b0;
  logic       RSTN = 1'b0;
  logic [2:0] gnt_id;
  logic       busy;
  logic       tmo_evt;

  uart_tx_arb_if #(.NREQ(4)) bus ();

  uart_tx_arb #(
    .NREQ    (4),
    .TMO_W   (8),
    .TMO_CYC (200)
  ) dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .bus     (bus),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .tmo_evt (tmo_evt)
  );

  always #5 CLK = ~CLK;

  int         n_pass    = 0;
  int         n_total   = 0;
  int         cyc       = 0;
  int         first_cyc = -1;
  int         last_cyc  = -1;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic       prev_stall = 1'b0;
  logic [7:0] stall_data = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: hold invariant under backpressure, and scoreboard pop on transfer.
  always @(negedge CLK) begin
    if (RSTN && prev_stall) begin
      chk("tx_hold_valid", int'(bus.tx_valid), 1);
      chk("tx_hold_data", int'(bus.tx_data), int'(stall_data));
    end
    if (RSTN && bus.tx_valid && bus.tx_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_byte", int'(bus.tx_data), 256);
      end else begin
        exp_b = exp_q.pop_front();
        chk("tx_data", int'(bus.tx_data), int'(exp_b));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
    prev_stall = RSTN && bus.tx_valid && !bus.tx_ready;
    stall_data = bus.tx_data;
  end

  task automatic chk_reset_outputs();
    chk("rst_tx_valid", int'(bus.tx_valid), 0);
    chk("rst_tx_data", int'(bus.tx_data), 0);
    chk("rst_gnt_id", int'(gnt_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tmo_evt", int'(tmo_evt), 0);
  endtask

  // Offer one byte from requester i and hold it until accepted.
  task automatic send_byte(input int i, input logic [7:0] d, input bit last);
    int n  = 0;
    bit ok = 1'b0;
    bus.req_valid[i]       = 1'b1;
    bus.req_data[8*i +: 8] = d;
    bus.req_last[i]        = last;
    while (!ok && n < 400) begin
      @(negedge CLK);
      if (bus.req_ready[i]) ok = 1'b1;
      else n++;
    end
    if (ok) begin
      @(posedge CLK);
      #1;
    end else begin
      chk("accept_timeout_wait", n, 0);
    end
    bus.req_valid[i] = 1'b0;
    bus.req_last[i]  = 1'b0;
  endtask

  task automatic wait_busy(input int exp_id);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!busy && n < 50);
    chk("grant_busy", int'(busy), 1);
    chk("gnt_id", int'(gnt_id), exp_id);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int start;
    int j;
    int good_v, good_d, good_r, good_t;
    bit seen;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b1;

    // Reset values
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset_outputs();
    RSTN = 1'b1;

    // Test 1: requester 1 alone, three bytes, 2-cycle latency, back-to-back
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    first_cyc = -1;
    start     = cyc;
    send_byte(1, 8'h41, 1'b0);
    send_byte(1, 8'h42, 1'b0);
    send_byte(1, 8'h43, 1'b1);
    chk("t1_busy_after_last", int'(busy), 0);
    repeat (3) @(negedge CLK);
    chk("t1_first_latency", first_cyc - start, 2);
    chk("t1_last_latency", last_cyc - start, 4);

    // Test 2: requesters 0 and 2 at reset exit; 0's packet first, no interleave
    @(posedge CLK);
    #1;
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h31);
    RSTN = 1'b1;
    fork
      begin
        send_byte(0, 8'h10, 1'b0);
        send_byte(0, 8'h11, 1'b1);
      end
      begin
        send_byte(2, 8'h30, 1'b0);
        send_byte(2, 8'h31, 1'b1);
      end
      wait_busy(0);
    join
    repeat (3) @(posedge CLK);
    #1;

    // Test 3: requester 3 under long backpressure; no timeout
    bus.tx_ready = 1'b0;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h5B);
    send_byte(3, 8'h5A, 1'b0);
    fork
      send_byte(3, 8'h5B, 1'b1);
      begin
        good_v = 0;
        good_d = 0;
        good_r = 0;
        good_t = 0;
        repeat (220) begin
          @(negedge CLK);
          if (bus.tx_valid) good_v++;
          if (bus.tx_data == 8'h5A) good_d++;
          if (!bus.req_ready[3]) good_r++;
          if (!tmo_evt) good_t++;
        end
        chk("t3_stall_valid", good_v, 220);
        chk("t3_stall_data", good_d, 220);
        chk("t3_stall_ready3", good_r, 220);
        chk("t3_stall_no_tmo", good_t, 220);
        @(posedge CLK);
        #1;
        bus.tx_ready = 1'b1;
      end
    join
    repeat (3) @(posedge CLK);
    #1;

    // Test 4: requester 1 goes silent mid-packet; timeout after 200 cycles
    exp_q.push_back(8'h77);
    send_byte(1, 8'h77, 1'b0);
    j    = 0;
    seen = 1'b0;
    while (!seen && j < 300) begin
      @(negedge CLK);
      if (tmo_evt) seen = 1'b1;
      else j++;
    end
    chk("t4_tmo_delay", j, 200);
    chk("t4_busy_after_tmo", int'(busy), 0);
    @(negedge CLK);
    chk("t4_tmo_one_cycle", int'(tmo_evt), 0);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h11);
    fork
      send_byte(2, 8'h22, 1'b1);
      send_byte(1, 8'h11, 1'b1);
      wait_busy(2);
    join
    repeat (3) @(posedge CLK);
    #1;

    // Test 5: reset during LOCK with a stalled byte; 0 granted first afterwards
    bus.tx_ready = 1'b0;
    send_byte(1, 8'h99, 1'b0);
    RSTN = 1'b0;
    @(posedge CLK);
    #1;
    chk_reset_outputs();
    RSTN         = 1'b1;
    bus.tx_ready = 1'b1;
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h3C);
    fork
      send_byte(0, 8'h0A, 1'b1);
      send_byte(3, 8'h3C, 1'b1);
      wait_busy(0);
    join
    repeat (3) @(posedge CLK);
    #1;

    // Test 6: 0 and 3 wait while 1 is locked; next grant depends on priority mode
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h62);
`ifdef UART_TX_ARB_PRIO0_EN
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hD3);
`else
    exp_q.push_back(8'hD3);
    exp_q.push_back(8'hA0);
`endif
    send_byte(1, 8'h61, 1'b0);
    fork
      begin
        send_byte(1, 8'h62, 1'b1);
`ifdef UART_TX_ARB_PRIO0_EN
        wait_busy(0);
`else
        wait_busy(3);
`endif
      end
      send_byte(0, 8'hA0, 1'b1);
      send_byte(3, 8'hD3, 1'b1);
    join
    repeat (5) @(posedge CLK);
    #1;
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
